i2c_write_sequencer: RTL and testbench
======================================

// Module: i2c_write_sequencer
// PURPOSE
//  Single-master I2C write controller that sequences the bus monitored by the i2c_raw decoder FSM.
//  Accepts one command (7-bit address + 1 data byte) over a valid/ready handshake.
//  Generates START, address+W, ACK check, data byte, ACK check and STOP on open-drain scl/sda.
//  Reports done/nack; sits between the host logic and the pad-level I2C buffers.
// PARAMETERS
//  CLK_DIV  250  clk cycles per quarter-bit phase; legal range >= 2; a bit slot is 4*CLK_DIV cycles
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  sequencer idle; command accepted on a clk edge where cmd_valid && cmd_ready
//  cmd_addr   in   7  7-bit slave address, sent MSB first
//  cmd_data   in   8  data byte, sent MSB first
//  scl_o      out  1  1 = release SCL (pulled high), 0 = drive low
//  sda_o      out  1  1 = release SDA, 0 = drive low
//  scl_in     in   1  sampled SCL pad, used only with I2C_CLK_STRETCH_EN
//  sda_in     in   1  sampled SDA pad, used for ACK
//  busy       out  1  high from accept until done
//  done       out  1  one-cycle pulse at transaction end
//  nack       out  1  valid with done; 1 = a slave NACK was seen
// BEHAVIOUR
//  Reset values (async):
//   - scl_o=1, sda_o=1, cmd_ready=1, busy=0, done=0, nack=0
//   - state=IDLE, phase and bit counters cleared
//  Reset mid-transaction: bus released immediately, command dropped, no done pulse.
//  Registers: phase counter 0..CLK_DIV-1; 2-bit quarter index P0..P3; 3-bit bit index 7..0.
//   - Outputs change only at quarter boundaries.
//  States and sequence:
//   - IDLE: cmd_ready=1.
//     - On accept, latch {cmd_addr,1'b0} and cmd_data.
//     - Go to START; cmd_ready=0 and busy=1 from the next cycle.
//   - START (1 slot), {scl,sda} per quarter: P0 11, P1 11, P2 10, P3 00.
//   - ADDR (8 slots): sda=bit for P0-P3; scl per quarter: P0 0, P1 0, P2 1, P3 1.
//   - ACK1 (1 slot): sda released.
//     - Sample sda_in on the last cycle of P2.
//     - sda_in=1 -> set nack, go to STOP (skip DATA).
//     - sda_in=0 -> go to DATA.
//   - DATA (8 slots): same waveform as ADDR.
//   - ACK2: same as ACK1; sda_in=1 sets nack; always go to STOP.
//   - STOP (1 slot), {scl,sda} per quarter: P0 00, P1 10, P2 11, P3 11.
//   - DONE (1 cycle): done=1, nack valid, busy=0; then IDLE with cmd_ready=1.
//     - nack clears on the next accept.
//  Latency: accept at edge T; START P0 begins at T+1; done is visible after edge T+1+N*4*CLK_DIV.
//   - N=20 slots for a full write.
//   - N=11 slots for an address NACK.
//  cmd_valid while busy is ignored; no queuing.
//  ACK/NACK and sda_in are sampled only in ACK slots.
//   - SDA sampled low outside ACK slots (bus contention) is not detected.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined:
//   - In any quarter where scl_o=1, the phase counter holds at 0 while scl_in=0.
//   - The phase counter advances only once scl_in=1, which supports slave clock stretching.
//   - Latency grows by the stretch cycles.
//  I2C_CLK_STRETCH_EN undefined:
//   - scl_in is ignored.
//   - Timing is fixed exactly as in BEHAVIOUR.
// TESTING (CLK_DIV=2)
//  - Reset released, idle 10 cycles -> scl_o=sda_o=1, cmd_ready=1, busy=0, done never pulses.
//  - Write addr 0x50, data 0xA5, sda_in=0 in both ACK slots:
//    - SDA bits at SCL rise are 1010000,0 then 10100101.
//    - done=1, nack=0 exactly at T+161.
//  - Write addr 0x3C with sda_in=1 in ACK1 -> no DATA slots, STOP follows; done=1, nack=1 at T+89.
//  - ACK1 ok, sda_in=1 in ACK2 -> full 20 slots; done=1, nack=1 at T+161.
//  - Assert reset during DATA bit 4 -> scl_o=sda_o=1 in the same cycle, no done; the next command completes normally.
//  - With I2C_CLK_STRETCH_EN, hold scl_in=0 for 10 cycles in ADDR bit 6 P2 -> done delayed to T+171, data unchanged.

Source files
------------

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
//   Single-master I2C write controller. Takes one command (7-bit address plus
//   one data byte) over a valid/ready handshake. It then emits START,
//   address+W, an ACK check, the data byte, a second ACK check and STOP on
//   open-drain SCL/SDA, and reports done/nack.
//
//   Parameter
//     CLK_DIV    clk cycles per quarter-bit phase (>= 2); one bit slot is 4*CLK_DIV
//
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous, active-high
//     cmd_valid  command present
//     cmd_ready  idle; a command is accepted on an edge where cmd_valid && cmd_ready
//     cmd_addr   7-bit slave address, sent MSB first
//     cmd_data   data byte, sent MSB first
//     scl_o      1 = release SCL, 0 = drive low
//     sda_o      1 = release SDA, 0 = drive low
//     scl_in     sampled SCL pad (clock stretching only)
//     sda_in     sampled SDA pad (ACK slots only)
//     busy       high from accept until done
//     done       one-cycle pulse at transaction end
//     nack       valid with done; 1 = a slave NACK was seen
//
//   Build option
//     I2C_CLK_STRETCH_EN  when defined, the phase counter holds at 0 in any
//                         SCL-high quarter while scl_in is still low.
module i2c_write_sequencer #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic [1:0]      quarter, quarter_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic            busy_nxt, nack_nxt;
  logic [7:0]      addr_byte, data_byte;
  logic            accept, phase_end, stall, ack_sample, bitv_nxt;

  // {scl, sda} for a given state and quarter; b is the bit being shifted out.
  function automatic logic [1:0] wave(input state_t s, input logic [1:0] q, input logic b);
    logic [1:0] w;
    w = 2'b11;
    case (s)
      START:      w = (q == 2'd2) ? 2'b10 : ((q == 2'd3) ? 2'b00 : 2'b11);
      ADDR, DATA: w = {q[1], b};
      ACK1, ACK2: w = {q[1], 1'b1};
      STOP:       w = (q == 2'd0) ? 2'b00 : ((q == 2'd1) ? 2'b10 : 2'b11);
      default:    w = 2'b11;
    endcase
    return w;
  endfunction

  assign cmd_ready = (state == IDLE) && !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == DONE);
  assign phase_end = (phase == PH_W'(CLK_DIV - 1));

`ifdef I2C_CLK_STRETCH_EN
  // A slave may hold SCL low after we release it; wait at phase 0 until it lets go.
  assign stall = scl_o && !scl_in && (phase == '0);
`else
  logic scl_in_unused;
  assign scl_in_unused = scl_in;
  assign stall = 1'b0;
`endif

  // ACK is taken on the last cycle of the SCL-high P2 quarter of an ACK slot.
  assign ack_sample = ((state == ACK1) || (state == ACK2)) && (quarter == 2'd2) &&
                      phase_end && !stall;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    quarter_nxt = quarter;
    bit_nxt     = bit_idx;
    busy_nxt    = busy;
    nack_nxt    = nack;
    case (state)
      IDLE: begin
        // The accept edge only latches; START begins one cycle later.
        if (busy) begin
          state_nxt   = START;
          phase_nxt   = '0;
          quarter_nxt = 2'd0;
        end else if (accept) begin
          busy_nxt = 1'b1;
          nack_nxt = 1'b0;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        if (ack_sample && sda_in)
          nack_nxt = 1'b1;
        if (!stall) begin
          phase_nxt = phase_end ? '0 : phase + PH_W'(1);
          if (phase_end) begin
            quarter_nxt = quarter + 2'd1;
            if (quarter == 2'd3) begin
              case (state)
                START: begin
                  state_nxt = ADDR;
                  bit_nxt   = 3'd7;
                end
                ADDR, DATA: begin
                  if (bit_idx == 3'd0)
                    state_nxt = (state == ADDR) ? ACK1 : ACK2;
                  else
                    bit_nxt = bit_idx - 3'd1;
                end
                ACK1: begin
                  state_nxt = nack ? STOP : DATA;
                  bit_nxt   = 3'd7;
                end
                ACK2: state_nxt = STOP;
                STOP: begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                end
                default: state_nxt = state;
              endcase
            end
          end
        end
      end
    endcase
  end

  assign bitv_nxt = (state_nxt == DATA) ? data_byte[bit_nxt] : addr_byte[bit_nxt];

  // Control and pad registers; pads are registered from next-state values so
  // the bus lines up with the state and changes only at quarter boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      quarter <= 2'd0;
      bit_idx <= 3'd0;
      busy    <= 1'b0;
      nack    <= 1'b0;
      scl_o   <= 1'b1;
      sda_o   <= 1'b1;
    end else begin
      state          <= state_nxt;
      phase          <= phase_nxt;
      quarter        <= quarter_nxt;
      bit_idx        <= bit_nxt;
      busy           <= busy_nxt;
      nack           <= nack_nxt;
      {scl_o, sda_o} <= wave(state_nxt, quarter_nxt, bitv_nxt);
    end
  end

  // Command payload; only meaningful while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_byte <= {cmd_addr, 1'b0};
      data_byte <= cmd_data;
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
module tb_i2c_write_sequencer;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       scl_o, sda_o, scl_in, sda_in;
  logic       busy, done, nack;

  i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .scl_o(scl_o), .sda_o(sda_o),
    .scl_in(scl_in), .sda_in(sda_in), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- slave model: wired-AND bus, ACK by pulling SDA low ----------------
  int   rc = 0;             // SCL rising edges seen in the current transaction
  logic ack1_drv = 1'b0;    // slave acknowledges the address
  logic ack2_drv = 1'b0;    // slave acknowledges the data
  logic slave_low;

  always_comb begin
    slave_low = 1'b0;
    if (ack1_drv && ((rc == 8 && !scl_o) || (rc == 9 && scl_o)))   slave_low = 1'b1;
    if (ack2_drv && ((rc == 17 && !scl_o) || (rc == 18 && scl_o))) slave_low = 1'b1;
  end
  assign sda_in = sda_o & ~slave_low;
  assign scl_in = scl_o;

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        nack;
    int          t_acc;
    int          lat;
    logic [31:0] bits;
    int          nbits;
  } exp_t;

  exp_t sbq[$];

  // Expected SDA level at every SCL rise, final nack and done latency.
  function automatic exp_t model(input logic [6:0] a, input logic [7:0] d,
                                 input logic k1, input logic k2, input int t);
    exp_t e;
    e.bits  = '0;
    e.nbits = 0;
    for (int i = 6; i >= 0; i--) begin e.bits = {e.bits[30:0], a[i]}; e.nbits++; end
    e.bits = {e.bits[30:0], 1'b0}; e.nbits++;          // W bit
    e.bits = {e.bits[30:0], 1'b1}; e.nbits++;          // master releases in ACK1
    if (k1) begin
      for (int i = 7; i >= 0; i--) begin e.bits = {e.bits[30:0], d[i]}; e.nbits++; end
      e.bits = {e.bits[30:0], 1'b1}; e.nbits++;        // ACK2 released
    end
    e.bits = {e.bits[30:0], 1'b0}; e.nbits++;          // STOP: SCL rises with SDA low
    e.nack  = !k1 || !k2;
    e.lat   = 1 + 4 * CLK_DIV * (k1 ? 20 : 11);
    e.t_acc = t;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic [31:0] cap = '0;
  int          ncap = 0, nstart = 0, nstop = 0;
  logic        scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy && !busy_prev) begin
        cap = '0; ncap = 0; rc = 0; nstart = 0; nstop = 0;
      end
      if (scl_o && !scl_prev) begin
        rc++;
        cap = {cap[30:0], sda_o};
        ncap++;
      end
      if (scl_o && scl_prev && sda_prev && !sda_o) nstart++;
      if (scl_o && scl_prev && !sda_prev && sda_o) nstop++;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("nack", 32'(nack), 32'(e.nack));
          chk("done_latency", 32'(cyc - e.t_acc), 32'(e.lat));
          chk("sda_bits", cap, e.bits);
          chk("bit_count", 32'(ncap), 32'(e.nbits));
          chk("start_count", 32'(nstart), 32'd1);
          chk("stop_count", 32'(nstop), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
      scl_prev  = scl_o;
      sda_prev  = sda_o;
      busy_prev = busy;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [6:0] a, input logic [7:0] d,
                      input logic k1, input logic k2, input bit hold_valid);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    chk("ready_before_send", 32'(cmd_ready), 32'd1);
    ack1_drv  = k1;
    ack2_drv  = k2;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back(model(a, d, k1, k2, cyc));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    if (hold_valid) begin
      // A command presented while busy must be ignored.
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        cmd_addr = 7'($urandom);
        cmd_data = 8'($urandom);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    chk("done_within_budget", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, scl_o, sda_o, cmd_ready, busy, done}, 32'b11100);
    chk("reset_nack", 32'(nack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_bus", {27'd0, scl_o, sda_o, cmd_ready, busy, done}, 32'b11100);
    end

    send(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0);
    send(7'h3C, 8'($urandom), 1'b0, 1'b1, 1'b0);
    send(7'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    send(7'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1);

    // Abort during DATA bit 4 (13th SCL rise).
    @(negedge clk);
    ack1_drv  = 1'b1;
    ack2_drv  = 1'b1;
    cmd_addr  = 7'h2A;
    cmd_data  = 8'h0F;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rc != 13 && n < 400) begin @(posedge clk); #2; n++; end
    chk("reached_data_bit4", 32'(rc), 32'd13);
    reset = 1'b1;
    #1;
    chk("abort_release", {28'd0, scl_o, sda_o, busy, done}, 32'b1100);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("after_abort_idle", {27'd0, scl_o, sda_o, cmd_ready, busy, done}, 32'b11100);
    send(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++)
      send(7'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
